load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit_pkg.sv | 46 ++++
 rtl/load_align_unit_extract.sv | 35 +++
 rtl/load_align_unit.sv | 125 ++++++++++++
 tb/tb_load_align_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/load_align_unit_pkg.sv
// CorePack: shared types for the load path.
//   addr_t / data_t       : byte address and 64-bit doubleword types
//   mem_op_enum           : load width/signedness selector
//   ld_state_e            : load FSM states
//   LD_TIMEOUT_DEFAULT    : default watchdog length in WAIT cycles
//   is_misaligned()       : natural-alignment test by access width
package CorePack;

    typedef logic [31:0] addr_t;
    typedef logic [63:0] data_t;

    typedef enum logic [2:0] {
        MEM_NO,
        MEM_B,
        MEM_H,
        MEM_W,
        MEM_D,
        MEM_UB,
        MEM_UH,
        MEM_UW
    } mem_op_enum;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_REQ,
        LD_WAIT,
        LD_DONE
    } ld_state_e;

    localparam int unsigned LD_TIMEOUT_DEFAULT = 255;

    // Alignment is judged by access width, so signed and unsigned
    // variants of the same width share one rule.
    function automatic logic is_misaligned(input mem_op_enum op, input logic [2:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_H, MEM_UH: mis = off[0];
            MEM_W, MEM_UW: mis = (off[1:0] != 2'b00);
            MEM_D:         mis = (off != 3'b000);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// load_extract: combinational byte-lane extraction for loads.
//   mem_op : load width/signedness
//   addr   : byte offset within the doubleword
//   rdata  : raw 64-bit doubleword from memory
//   data   : shifted, truncated and sign/zero-extended result
// Bytes beyond bit 63 come in as zero from the logical shift; there is
// no cross-doubleword access.
module load_extract
    import CorePack::*;
(
    input  mem_op_enum  mem_op,
    input  logic [2:0]  addr,
    input  data_t       rdata,
    output data_t       data
);

    data_t shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        data = '0;
        case (mem_op)
            MEM_B:   data = {{56{shifted[7]}},  shifted[7:0]};
            MEM_H:   data = {{48{shifted[15]}}, shifted[15:0]};
            MEM_W:   data = {{32{shifted[31]}}, shifted[31:0]};
            MEM_D:   data = rdata;
            MEM_UB:  data = {56'd0, shifted[7:0]};
            MEM_UH:  data = {48'd0, shifted[15:0]};
            MEM_UW:  data = {32'd0, shifted[31:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: single-outstanding load sequencer with byte alignment.
//   clk, rst            : clock, synchronous active-high reset
//   ld_valid/ld_ready   : core request handshake (ready only in IDLE)
//   ld_op, ld_addr      : load type and byte address
//   dmem_req_valid/ready, dmem_raddr : doubleword-aligned memory request
//   dmem_resp_valid, dmem_rdata      : memory response
//   ld_done, ld_data, ld_err         : one-cycle completion, held result
// Optional feature: define MISALIGN_CHECK_EN to fail misaligned H/W/D
// loads immediately with ld_err instead of issuing them.
//
// state   | meaning
// --------+------------------------------------------------------
// LD_IDLE | ready for a new load
// LD_REQ  | memory request presented, waiting for dmem_req_ready
// LD_WAIT | request accepted, waiting for response or watchdog
// LD_DONE | ld_done pulse, result registered
module load_align_unit
    import CorePack::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LD_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  mem_op_enum  ld_op,
    input  addr_t       ld_addr,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output addr_t       dmem_raddr,
    input  logic        dmem_resp_valid,
    input  data_t       dmem_rdata,
    output logic        ld_done,
    output data_t       ld_data,
    output logic        ld_err
);

    ld_state_e   state;
    mem_op_enum  op_q;
    logic [2:0]  off_q;
    logic [31:0] wdog_cnt;
    data_t       ext_data;
    logic        early_fail;

    assign ld_ready = (state == LD_IDLE);

`ifdef MISALIGN_CHECK_EN
    assign early_fail = is_misaligned(ld_op, ld_addr[2:0]);
`else
    assign early_fail = 1'b0;
`endif

    load_extract u_extract (
        .mem_op (op_q),
        .addr   (off_q),
        .rdata  (dmem_rdata),
        .data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LD_IDLE;
            op_q           <= MEM_NO;
            off_q          <= 3'd0;
            wdog_cnt       <= 32'd0;
            dmem_req_valid <= 1'b0;
            dmem_raddr     <= '0;
            ld_done        <= 1'b0;
            ld_data        <= '0;
            ld_err         <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (ld_valid) begin
                        op_q  <= ld_op;
                        off_q <= ld_addr[2:0];
                        if (ld_op == MEM_NO || early_fail) begin
                            state   <= LD_DONE;
                            ld_done <= 1'b1;
                            ld_data <= '0;
                            ld_err  <= early_fail;
                        end else begin
                            state          <= LD_REQ;
                            dmem_req_valid <= 1'b1;
                            dmem_raddr     <= {ld_addr[31:3], 3'b000};
                        end
                    end
                end
                LD_REQ: begin
                    // A response coincident with this handshake is for
                    // nobody we know about and is dropped by not looking.
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                        wdog_cnt       <= 32'd0;
                        state          <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (dmem_resp_valid) begin
                        ld_data <= ext_data;
                        ld_err  <= 1'b0;
                        ld_done <= 1'b1;
                        state   <= LD_DONE;
                    end else if (TIMEOUT_CYCLES != 0 &&
                                 wdog_cnt == TIMEOUT_CYCLES - 32'd1) begin
                        ld_data <= '0;
                        ld_err  <= 1'b1;
                        ld_done <= 1'b1;
                        state   <= LD_DONE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 32'd1;
                    end
                end
                LD_DONE: begin
                    state <= LD_IDLE;
                end
                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;
    import CorePack::*;

    localparam int TMO = 8;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    mem_op_enum  ld_op = MEM_NO;
    addr_t       ld_addr = '0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    addr_t       dmem_raddr;
    logic        dmem_resp_valid = 1'b0;
    data_t       dmem_rdata = '0;
    logic        ld_done;
    data_t       ld_data;
    logic        ld_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];

    load_align_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_op           (ld_op),
        .ld_addr         (ld_addr),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_raddr      (dmem_raddr),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_rdata      (dmem_rdata),
        .ld_done         (ld_done),
        .ld_data         (ld_data),
        .ld_err          (ld_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Byte-by-byte reference: gather the bytes the access covers, then extend.
    function automatic logic [63:0] ref_load(input mem_op_enum op, input logic [2:0] off,
                                             input logic [63:0] rd);
        logic [63:0] r;
        int nb;
        bit sgn;
        r = '0;
        nb = 0;
        sgn = 0;
        case (op)
            MEM_B:  begin nb = 1; sgn = 1; end
            MEM_H:  begin nb = 2; sgn = 1; end
            MEM_W:  begin nb = 4; sgn = 1; end
            MEM_D:  begin nb = 8; sgn = 0; end
            MEM_UB: begin nb = 1; sgn = 0; end
            MEM_UH: begin nb = 2; sgn = 0; end
            MEM_UW: begin nb = 4; sgn = 0; end
            default: nb = 0;
        endcase
        if (op == MEM_D) return rd;
        for (int i = 0; i < 8; i++)
            if (i < nb && (int'(off) + i) < 8)
                r[i*8 +: 8] = rd[(int'(off) + i)*8 +: 8];
        if (sgn && nb > 0 && r[nb*8-1])
            for (int i = 0; i < 64; i++)
                if (i >= nb*8) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit bench_misaligned(input mem_op_enum op, input logic [2:0] off);
        if (op == MEM_H || op == MEM_UH) return off % 2 != 0;
        if (op == MEM_W || op == MEM_UW) return off % 4 != 0;
        if (op == MEM_D) return off != 0;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (ld_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", ld_done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ld_data", ld_data, e.data);
                chk("ld_err", ld_err, e.err);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // resp_dly < 0 means memory never answers (watchdog path).
    task automatic do_load(input mem_op_enum op, input logic [31:0] addr, input logic [63:0] rdata,
                           input int rdy_dly, input int resp_dly, input bit early,
                           input bit has_lit, input logic [63:0] lit);
        exp_t e;
        int n;
        bit mis;
        bit short_path;
        mis = 0;
`ifdef MISALIGN_CHECK_EN
        mis = bench_misaligned(op, addr[2:0]);
`endif
        short_path = (op == MEM_NO) || mis;
        n = 0;
        @(negedge clk);
        while (!ld_ready && n < 20) begin @(negedge clk); n++; end
        chk("ready_wait", ld_ready, 1'b1);
        ld_valid = 1'b1;
        ld_op    = op;
        ld_addr  = addr;
        if (short_path) begin
            e.cyc = cyc + 1; e.data = '0; e.err = mis;
        end else if (resp_dly < 0) begin
            e.cyc = cyc + 2 + rdy_dly + TMO; e.data = '0; e.err = 1'b1;
        end else begin
            e.cyc = cyc + 3 + rdy_dly + resp_dly;
            e.data = has_lit ? lit : ref_load(op, addr[2:0], rdata);
            e.err = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_op    = MEM_NO;
        if (short_path) begin
            @(negedge clk);
            chk("no_req", dmem_req_valid, 1'b0);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                @(negedge clk);
                chk("req_valid", dmem_req_valid, 1'b1);
                chk("raddr", dmem_raddr, {addr[31:3], 3'b000});
            end
            dmem_req_ready = 1'b1;
            if (early) begin
                dmem_resp_valid = 1'b1;
                dmem_rdata      = ~rdata;
            end
            @(posedge clk); #1;
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b0;
            if (resp_dly >= 0) begin
                repeat (resp_dly) @(negedge clk);
                @(negedge clk);
                dmem_resp_valid = 1'b1;
                dmem_rdata      = rdata;
                @(posedge clk); #1;
                dmem_resp_valid = 1'b0;
                dmem_rdata      = {$urandom, $urandom};
            end
        end
        n = 0;
        while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("done_seen", sb.size(), 0);
        @(negedge clk);
        chk("hold_data", ld_data, e.data);
        chk("hold_err", ld_err, e.err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ld_ready, 1'b1);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_raddr", dmem_raddr, 0);
        chk("rst_done", ld_done, 1'b0);
        chk("rst_data", ld_data, 0);
        chk("rst_err", ld_err, 1'b0);

        do_load(MEM_B, 32'h1003, 64'h0000_0000_80FF_0000, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FF80);
        do_load(MEM_UH, 32'h2006, 64'hBEEF_0000_0000_0000, 0, 0, 0, 1, 64'h0000_0000_0000_BEEF);
        do_load(MEM_W, 32'h10, 64'h1234_5678_9ABC_DEF0, 4, 0, 0, 0, '0);
        do_load(MEM_NO, 32'h88, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, '0);
        do_load(MEM_D, 32'h3000, 64'hDEAD_BEEF_CAFE_F00D, 1, 2, 0, 0, '0);
        do_load(MEM_UW, 32'h3004, 64'hF234_5678_0000_0000, 0, 1, 0, 0, '0);
        do_load(MEM_B, 32'h3007, 64'h7F00_0000_0000_0000, 0, 0, 0, 0, '0);
        do_load(MEM_W, 32'h1002, 64'h0000_8765_4321_0000, 0, 0, 0, 0, '0);
        do_load(MEM_H, 32'h4007, 64'h8000_0000_0000_0000, 0, 0, 0, 0, '0);
        do_load(MEM_UW, 32'h4006, 64'hABCD_0000_0000_0000, 0, 0, 0, 0, '0);
        do_load(MEM_H, 32'h5002, 64'h0000_0000_9001_0000, 0, 3, 1, 0, '0);

        // Watchdog, then a late response that must be ignored.
        do_load(MEM_D, 32'h6000, 64'h1111_2222_3333_4444, 0, -1, 0, 0, '0);
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'h5555_6666_7777_8888;
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_resp_data", ld_data, 0);
        chk("late_resp_err", ld_err, 1'b1);

        // Reset while in WAIT, stale response afterwards.
        @(negedge clk);
        ld_valid = 1'b1; ld_op = MEM_W; ld_addr = 32'h40;
        @(posedge clk); #1 ld_valid = 1'b0;
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(posedge clk); #1 dmem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wrst_ready", ld_ready, 1'b1);
        chk("wrst_req_valid", dmem_req_valid, 1'b0);
        chk("wrst_raddr", dmem_raddr, 0);
        chk("wrst_data", ld_data, 0);
        chk("wrst_err", ld_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        dmem_resp_valid = 1'b1;
        dmem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1 dmem_resp_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("stale_no_done", ld_done, 1'b0);
        end
        chk("stale_data", ld_data, 0);
        do_load(MEM_W, 32'h44, 64'h8000_0001_0000_0000, 0, 0, 0, 0, '0);

        for (int k = 0; k < 16; k++) begin
            do_load(mem_op_enum'($urandom_range(0, 7)), $urandom, {$urandom, $urandom},
                    $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, '0);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
